// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions for the register slave: response codes and
// the byte-address to register-index shift.
package axil_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    // Register index is the byte address with the byte-lane bits dropped.
    function automatic int idx_shift(input int strb_width);
        return $clog2(strb_width);
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage for the AXI-Lite slave: one byte-strobed write port and
// one asynchronous read port, so a same-edge read sees the pre-write value.
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int REG_COUNT  = 16,
    parameter int IDX_WIDTH  = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wr_strb[b]) begin
                    regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_data = regs[rd_idx];

endmodule

// File: rtl/axil_reg_slave.sv
// AXI-Lite register slave: independent AW/W holding registers, a write that
// fires once both are held and B is free, and a 1-cycle registered read path.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int REG_COUNT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,

    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,

    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,

    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int IDX_WIDTH = $clog2(REG_COUNT);
    localparam int IDX_SHIFT = idx_shift(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] REG_LIMIT = ADDR_WIDTH'(REG_COUNT);

    logic                  ready_en;

    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  aw_held;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic                  w_held;

    resp_t                 bresp_q;
    logic                  bvalid_q;
    resp_t                 rresp_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  do_write;

    logic [ADDR_WIDTH-1:0] aw_full_idx;
    logic [ADDR_WIDTH-1:0] ar_full_idx;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] bank_rd_data;

    // Protection bits carry no meaning for this slave.
    logic                  unused_prot;
    assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

    assign s_axil_awready = ready_en && !aw_held;
    assign s_axil_wready  = ready_en && !w_held;
    assign s_axil_arready = ready_en && (!rvalid_q || s_axil_rready);

    assign aw_hs    = s_axil_awvalid && s_axil_awready;
    assign w_hs     = s_axil_wvalid && s_axil_wready;
    assign ar_hs    = s_axil_arvalid && s_axil_arready;
    assign do_write = aw_held && w_held && (!bvalid_q || s_axil_bready);

    assign aw_full_idx = aw_addr_q >> IDX_SHIFT;
    assign ar_full_idx = s_axil_araddr >> IDX_SHIFT;
    assign aw_in_range = aw_full_idx < REG_LIMIT;
    assign ar_in_range = ar_full_idx < REG_LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Write-address and write-data holding registers fill independently and
    // are released together when the write fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_axil_awaddr;
            end else if (do_write) begin
                aw_held   <= 1'b0;
            end
            if (w_hs) begin
                w_held    <= 1'b1;
                w_data_q  <= s_axil_wdata;
                w_strb_q  <= s_axil_wstrb;
            end else if (do_write) begin
                w_held    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (do_write) begin
            bvalid_q <= 1'b1;
            bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axil_bready) begin
            bvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_q  <= ar_in_range ? bank_rd_data : '0;
        end else if (s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    axil_reg_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (do_write && aw_in_range),
        .wr_idx  (aw_full_idx[IDX_WIDTH-1:0]),
        .wr_data (w_data_q),
        .wr_strb (w_strb_q),
        .rd_idx  (ar_full_idx[IDX_WIDTH-1:0]),
        .rd_data (bank_rd_data)
    );

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rresp  = rresp_q;
    assign s_axil_rdata  = rdata_q;

endmodule

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits (32 or 64).
REQ-002 Parameter ADDR_WIDTH, default 16, byte-address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8, write-strobe width.
REQ-004 Parameter REG_COUNT, default 16, number of DATA_WIDTH-bit registers (power of two, at least 2).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1;  s_axil_awready  out  1  write-address channel.
REQ-008 s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1;  s_axil_wready  out  1  write-data channel.
REQ-009 s_axil_bresp  out  2;  s_axil_bvalid  out  1;  s_axil_bready  in  1  write-response channel.
REQ-010 s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1;  s_axil_arready  out  1  read-address channel.
REQ-011 s_axil_rdata  out  DATA_WIDTH;  s_axil_rresp  out  2;  s_axil_rvalid  out  1;  s_axil_rready  in  1  read-data channel.

Function
REQ-012 Register index = addr >> log2(STRB_WIDTH); index >= REG_COUNT is out of range; awprot/arprot are ignored.
REQ-013 AW and W are accepted independently, each into a one-entry holding register; awready = ready_en && !aw_held; wready = ready_en && !w_held.
REQ-014 A write executes on the edge where aw_held && w_held && (!bvalid || bready); that edge clears both held flags, sets bvalid and loads bresp.
REQ-015 In-range write updates only the bytes whose wstrb bit is 1 and returns bresp OKAY (2'b00); out-of-range write modifies nothing and returns SLVERR (2'b10).
REQ-016 Write latency: bvalid is high 2 cycles after the edge completing the later of the AW/W handshakes when B is idle; sustained write throughput is one write per 2 cycles.
REQ-017 bvalid and bresp hold stable until the bready handshake; a new write executing on the same edge keeps bvalid high and loads its own bresp.
REQ-018 arready = ready_en && (!rvalid || rready); on an AR handshake, rvalid, rdata and rresp are loaded on the same edge (1-cycle latency).
REQ-019 In-range read returns the register value with rresp OKAY; out-of-range read returns rdata 0 with rresp SLVERR.
REQ-020 rvalid, rdata and rresp hold stable until the rready handshake; back-to-back reads sustain one read per cycle while rready is high.
REQ-021 Read and write to the same register on the same edge: the read returns the pre-write value.
REQ-022 Read and write paths are fully independent; neither stalls the other.

Reset
REQ-023 While rst is high at an edge: all registers are 0, aw_held, w_held, bvalid and rvalid are 0, bresp and rresp are 2'b00, rdata is 0, ready_en is 0.
REQ-024 ready_en sets on the first edge with rst low, so all readies are 0 during reset and in the first cycle after reset deasserts.
REQ-025 Reset mid-transaction discards held AW/W data and any pending B/R response without updating any register.

Structure
REQ-026 Shared package axil_pkg holds the resp typedef (2 bits), RESP_OKAY, RESP_SLVERR and the index-shift function.
REQ-027 Sub-module axil_reg_bank holds the storage array, the strobe-merge write port and the single combinational read port; the handshake and control logic stays in the top level.

Verification
REQ-028 AW addr 0x0004 and W data 0xDEADBEEF/strb 0xF handshake on the same cycle, bready=1 -> bvalid 2 cycles later with bresp 00; then AR 0x0004 -> rvalid next cycle with rdata 0xDEADBEEF, rresp 00.
REQ-029 W 0x11223344/strb 0x3 handshakes 3 cycles before AW 0x0008, with reg2 = 0xAABBCCDD beforehand -> wready low after W handshake, write executes only after AW, reg2 reads 0xAABB3344.
REQ-030 AW 0x0040 (index 16, REG_COUNT=16) with W 0xFFFFFFFF -> bresp 10, all registers unchanged; AR 0x0040 -> rdata 0, rresp 10.
REQ-031 bready held low for 5 cycles with a second AW+W already sent -> bvalid/bresp stable, awready/wready low once held, second bvalid follows the first bready handshake.
REQ-032 rst asserted for 1 cycle while aw_held=1 and rvalid=1 -> the cycle after: bvalid=0, rvalid=0, all readies 0 for one cycle, the targeted register still 0.
REQ-033 Same-edge AW+W to 0x000C (data 0x5) and AR 0x000C with the register at 0x1 -> read returns 0x1; a following read returns 0x5.
